mem_access: RTL
===============

# mem_access

Memory-access stage of the 5-stage CPU pipeline, between the ex_mem and mem_wb pipeline registers. It decodes load/store ops, runs a single-outstanding req/ack data-bus transaction, aligns and extends load data, and drives the write-back result into mem_wb. It raises `stallreq` to ctrl while an access is in flight. Non-memory instructions pass through combinationally with zero added latency.

## Interface
- No parameters. Widths come from shared defines: `RegBus` = 32, `RegAddrBus` = 5, `AluOpBus` = 8.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1 — clock.
- `rst` in 1 — synchronous, active-high reset.
- `stall` in 6 — from ctrl; bit 4 = 1 means the mem stage is frozen this cycle.
- `mem_wd_i` in 5 — destination register, from ex_mem.
- `mem_wreg_i` in 1 — register write enable, from ex_mem.
- `mem_wdata_i` in 32 — ALU result, from ex_mem.
- `mem_whilo_i` in 1, `mem_hi_i` in 32, `mem_lo_i` in 32 — HI/LO write, from ex_mem.
- `mem_aluop_i` in 8 — op code, from ex_mem.
- `mem_addr_i` in 32 — effective address.
- `mem_reg2_i` in 32 — store data (rt).
- `mem_wd`, `mem_wreg`, `mem_wdata`, `mem_whilo`, `mem_hi`, `mem_lo` out — results to mem_wb; same widths as the inputs.
- `stallreq` out 1 — stall request to ctrl.
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out 32, `bus_sel` out 4, `bus_wdata` out 32 — data-bus request.
- `bus_rdata` in 32, `bus_ack` in 1 — data-bus response.

## Operation
- Memory ops: LB, LBU, LH, LHU, LW, SB, SH, SW. All other ops pass through: outputs equal inputs, `stallreq` = 0.
- Byte lanes are big-endian. Address bits [1:0] = 0 select byte lane [31:24] (`bus_sel` = 1000).
  - Halfword at offset 0 → `bus_sel` = 1100; at offset 2 → 0011.
  - Word → 1111.
- Store data is replicated across all lanes (byte ×4, halfword ×2). `bus_addr` = {addr[31:2], 2'b00}.
- Loads: the selected lane is sign-extended (LB, LH) or zero-extended (LBU, LHU) into `mem_wdata`.
- Misaligned access (halfword with addr[0] = 1, word with addr[1:0] ≠ 0):
  - No bus request is issued and `stallreq` stays 0.
  - `mem_wreg` is forced to 0; all other fields pass through.
- State machine:
  - IDLE: on an aligned memory op, `stallreq` = 1 and go to BUSY. Other ops stay in IDLE.
  - BUSY: `bus_req` = 1. `bus_we`, `bus_addr`, `bus_sel`, `bus_wdata` are registered and held stable until ack. `stallreq` = 1. On `bus_ack`, capture `bus_rdata` into a read buffer and go to HOLD.
  - HOLD: `bus_req` = 0, `stallreq` = 0. Outputs use the read buffer. When stall[4] = 0, go to IDLE. While stall[4] = 1, stay in HOLD; the access is never reissued.
- `bus_ack` is ignored outside BUSY.
- Stores keep `mem_wreg` = `mem_wreg_i` (0 from decode).

## Timing
- While `rst` = 1, all outputs are 0. Next state is IDLE; the read buffer and llbit are cleared.
- Reset during BUSY drops `bus_req` the next cycle. The pending ack is ignored.
- Minimum memory-op cost is 3 cycles: IDLE (detect), BUSY (ack in the same cycle), HOLD (result valid, stage advances at the clock edge).
- Each additional ack-wait cycle adds one cycle of `stallreq`.
- Exactly one `bus_req` episode per instruction.
- The pass-through path is combinational. `stallreq` is combinational from state and decode.

## Configuration
- `MEM_LLSC_EN` defined: LL and SC ops are supported, using an internal llbit register.
  - LL behaves as LW and sets llbit = 1.
  - SC with llbit = 1: performs SW, writes `mem_wdata` = 1, clears llbit.
  - SC with llbit = 0: no bus access, `mem_wdata` = 0, `mem_wreg` kept.
- Not defined: LL and SC are treated as non-memory pass-through ops, and no llbit register exists.

## Structure
- Op codes (`EXE_LB_OP` … `EXE_SC_OP`), `RegBus`, `RegAddrBus`, `AluOpBus`, and state encodings live in the shared defines file.
- One combinational sub-module, `mem_align`: computes lane select, store-data replication, load extraction/extension, and the misalignment flag.

## Test plan
- LW, addr 0x100, ack in BUSY cycle, `bus_rdata` 0xDEADBEEF → `stallreq` high 2 cycles; `mem_wdata` = 0xDEADBEEF, `mem_wreg` = 1 in HOLD.
- LB, addr 0x101, `bus_rdata` 0x1280FF34 → `bus_sel` 0100, `mem_wdata` 0xFFFFFF80. LBU at the same address → 0x00000080.
- SH, addr 0x202, reg2 0x0000BEEF, ack delayed 3 cycles → single `bus_req` episode, `bus_sel` 0011, `bus_wdata` 0xBEEFBEEF, `bus_we` 1 held stable, `stallreq` high 5 cycles.
- LW, addr 0x102 → no `bus_req`, `stallreq` 0, `mem_wreg` 0.
- `rst` pulsed during BUSY → next cycle `bus_req` 0, all outputs 0. A late ack does not disturb the next op.
- With `MEM_LLSC_EN`: LL then SC → SC issues the write and `mem_wdata` 1. A second SC → no bus access, `mem_wdata` 0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared widths, ALU op codes and FSM encoding for the memory-access stage.
package mem_access_pkg;
    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int AluOpBus   = 8;

    localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'b1110_1011;
    localparam logic [AluOpBus-1:0] EXE_LL_OP  = 8'b1111_0000;
    localparam logic [AluOpBus-1:0] EXE_SC_OP  = 8'b1111_1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;
endpackage

// File: rtl/mem_access_align.sv
// Load/store decode, big-endian lane select, store replication, load extension.
// LL/SC decode is present only when MEM_LLSC_EN is defined.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [AluOpBus-1:0] aluop,
    input  logic [1:0]          offset,
    input  logic [RegBus-1:0]   reg2,
    input  logic [RegBus-1:0]   rdata,
    output logic                is_mem,
    output logic                is_load,
    output logic                is_ll,
    output logic                is_sc,
    output logic                misaligned,
    output logic [3:0]          sel,
    output logic [RegBus-1:0]   store_data,
    output logic [RegBus-1:0]   load_data
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Offset 0 is the most significant lane, so shift by the complement.
    assign lane_b = 8'(rdata >> {~offset, 3'b000});
    assign lane_h = 16'(rdata >> {~offset[1], 4'b0000});

    always_comb begin
        is_mem     = 1'b1;
        is_load    = 1'b0;
        is_ll      = 1'b0;
        is_sc      = 1'b0;
        misaligned = 1'b0;
        sel        = 4'b0000;
        store_data = reg2;
        load_data  = rdata;
        case (aluop)
            EXE_LB_OP: begin
                is_load = 1'b1; sel = 4'b1000 >> offset;
                load_data = {{24{lane_b[7]}}, lane_b};
            end
            EXE_LBU_OP: begin
                is_load = 1'b1; sel = 4'b1000 >> offset;
                load_data = {24'b0, lane_b};
            end
            EXE_LH_OP: begin
                is_load = 1'b1; misaligned = offset[0];
                sel = offset[1] ? 4'b0011 : 4'b1100;
                load_data = {{16{lane_h[15]}}, lane_h};
            end
            EXE_LHU_OP: begin
                is_load = 1'b1; misaligned = offset[0];
                sel = offset[1] ? 4'b0011 : 4'b1100;
                load_data = {16'b0, lane_h};
            end
            EXE_LW_OP: begin
                is_load = 1'b1; misaligned = |offset; sel = 4'b1111;
            end
            EXE_SB_OP: begin
                sel = 4'b1000 >> offset; store_data = {4{reg2[7:0]}};
            end
            EXE_SH_OP: begin
                misaligned = offset[0]; sel = offset[1] ? 4'b0011 : 4'b1100;
                store_data = {2{reg2[15:0]}};
            end
            EXE_SW_OP: begin
                misaligned = |offset; sel = 4'b1111;
            end
`ifdef MEM_LLSC_EN
            EXE_LL_OP: begin
                is_load = 1'b1; is_ll = 1'b1; misaligned = |offset; sel = 4'b1111;
            end
            EXE_SC_OP: begin
                is_sc = 1'b1; misaligned = |offset; sel = 4'b1111;
            end
`endif
            default: is_mem = 1'b0;
        endcase
    end
endmodule

// File: rtl/mem_access.sv
// Memory-access stage: single-outstanding req/ack data-bus access with load alignment.
// Defining MEM_LLSC_EN adds LL/SC support backed by an llbit register.
module mem_access
    import mem_access_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            stall,
    input  logic [RegAddrBus-1:0] mem_wd_i,
    input  logic                  mem_wreg_i,
    input  logic [RegBus-1:0]     mem_wdata_i,
    input  logic                  mem_whilo_i,
    input  logic [RegBus-1:0]     mem_hi_i,
    input  logic [RegBus-1:0]     mem_lo_i,
    input  logic [AluOpBus-1:0]   mem_aluop_i,
    input  logic [RegBus-1:0]     mem_addr_i,
    input  logic [RegBus-1:0]     mem_reg2_i,
    output logic [RegAddrBus-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [RegBus-1:0]     mem_wdata,
    output logic                  mem_whilo,
    output logic [RegBus-1:0]     mem_hi,
    output logic [RegBus-1:0]     mem_lo,
    output logic                  stallreq,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [RegBus-1:0]     bus_addr,
    output logic [3:0]            bus_sel,
    output logic [RegBus-1:0]     bus_wdata,
    input  logic [RegBus-1:0]     bus_rdata,
    input  logic                  bus_ack
);
    state_t              state;
    logic                req_q, we_q;
    logic [3:0]          sel_q;
    logic [RegBus-1:0]   addr_q, wdata_q, rbuf;
    logic                is_mem, is_load, is_ll, is_sc, misaligned;
    logic [3:0]          sel;
    logic [RegBus-1:0]   store_data, load_data;
    logic                llbit, start;
    logic                unused_stall;

    assign unused_stall = ^{stall[5], stall[3:0]};

    mem_align u_align (
        .aluop      (mem_aluop_i),
        .offset     (mem_addr_i[1:0]),
        .reg2       (mem_reg2_i),
        .rdata      (rbuf),
        .is_mem     (is_mem),
        .is_load    (is_load),
        .is_ll      (is_ll),
        .is_sc      (is_sc),
        .misaligned (misaligned),
        .sel        (sel),
        .store_data (store_data),
        .load_data  (load_data)
    );

    // A failed SC behaves like a non-memory op: no bus access, result 0.
    assign start = (state == IDLE) && is_mem && !misaligned && !(is_sc && !llbit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= BUSY;
                    req_q   <= 1'b1;
                    we_q    <= !is_load;
                    sel_q   <= sel;
                    addr_q  <= {mem_addr_i[31:2], 2'b00};
                    wdata_q <= is_load ? '0 : store_data;
                end
                BUSY: if (bus_ack) begin
                    state <= HOLD;
                    req_q <= 1'b0;
                    rbuf  <= bus_rdata;
                end
                HOLD: if (!stall[4]) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_LLSC_EN
    always_ff @(posedge clk) begin
        if (rst)
            llbit <= 1'b0;
        else if (state == BUSY && bus_ack) begin
            if (is_ll)      llbit <= 1'b1;
            else if (is_sc) llbit <= 1'b0;
        end
    end
`else
    logic unused_ll;
    assign llbit     = 1'b0;
    assign unused_ll = is_ll;
`endif

    always_comb begin
        mem_wd    = '0;
        mem_wreg  = 1'b0;
        mem_wdata = '0;
        mem_whilo = 1'b0;
        mem_hi    = '0;
        mem_lo    = '0;
        stallreq  = 1'b0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_sel   = '0;
        bus_wdata = '0;
        if (!rst) begin
            mem_wd    = mem_wd_i;
            mem_wreg  = mem_wreg_i;
            mem_wdata = mem_wdata_i;
            mem_whilo = mem_whilo_i;
            mem_hi    = mem_hi_i;
            mem_lo    = mem_lo_i;
            // An SC that reached HOLD has succeeded; llbit was cleared on its ack.
            if (is_mem && misaligned)         mem_wreg  = 1'b0;
            else if (is_sc)                   mem_wdata = {31'b0, (state == HOLD) || llbit};
            else if (is_load && state == HOLD) mem_wdata = load_data;
            stallreq  = start || (state == BUSY);
            bus_req   = req_q;
            bus_we    = we_q;
            bus_addr  = addr_q;
            bus_sel   = sel_q;
            bus_wdata = wdata_q;
        end
    end
endmodule
